// File: rtl/cell_pos_reader_if.sv
// Bus bundle for cell_pos_reader: cell-memory read port plus the
// valid/ready particle stream toward the pos cache / force front end.
interface cell_pos_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  // cell memory side
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  // particle stream side
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  // reader drives the memory port and the stream
  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_data, out_index, out_last, out_valid,
    input  out_ready
  );

  // memory + consumer view
  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_data, out_index, out_last, out_valid,
    output out_ready
  );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the particle count at address 0 of a cell position RAM, then
// streams particles 1..N out with backpressure. Reads are credit-limited
// so every read in flight always has a FIFO slot waiting for it.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int RD_LATENCY   = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  cell_pos_reader_if.master     bus
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int FIW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int WCW = $clog2(RD_LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] MAX_IDX = ADDR_WIDTH'(PARTICLE_NUM - 1);

  typedef enum logic [2:0] {
    IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, FINISH
  } state_t;

  state_t state, state_nx;

  // control / addressing
  logic [ADDR_WIDTH-1:0] nxt_addr;   // next particle address to issue
  logic [ADDR_WIDTH-1:0] last_addr;  // address held on the bus between reads
  logic [ADDR_WIDTH-1:0] count_r;    // clamped particle count
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] cnt_clamped;
  logic [WCW-1:0]        wait_cnt;
  logic                  cnt_ready;
  logic                  issue;
  logic                  rden;

  // in-flight read tags: bit k set means a particle read issued k cycles ago
  logic [RD_LATENCY:1]                 vld_pipe;
  logic [RD_LATENCY:1][ADDR_WIDTH-1:0] idx_pipe;

  // output FIFO, shift style: entry 0 is always the head, so the stream
  // outputs come straight from flops. Empty entries are kept at zero.
  logic [FIFO_DEPTH-1:0]                 f_vld;
  logic [FIFO_DEPTH-1:0]                 f_last;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] f_data;
  logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] f_idx;
  logic [FCW-1:0]                        f_cnt;
  logic [FIW-1:0]                        wr_pos;
  logic [OCW-1:0]                        occ;
  logic                                  push, pop;

  // count word clamp and the cycle in which it is on mem_q
  assign cnt_clamped = (bus.mem_q[ADDR_WIDTH-1:0] > MAX_IDX) ? MAX_IDX
                                                            : bus.mem_q[ADDR_WIDTH-1:0];
  assign cnt_ready   = (state == WAIT_CNT) && (wait_cnt == WCW'(RD_LATENCY - 1));

  // credit check: buffered entries plus reads in flight; a pop in this
  // same cycle is deliberately not counted as free space
  always_comb begin
    occ = OCW'(f_cnt);
    for (int i = 1; i <= RD_LATENCY; i++) occ = occ + OCW'(vld_pipe[i]);
  end

  assign issue = (state == STREAM) && (occ < OCW'(FIFO_DEPTH));
  assign push  = vld_pipe[RD_LATENCY];
  assign pop   = f_vld[0] && bus.out_ready;
  assign wr_pos = FIW'(pop ? (f_cnt - FCW'(1)) : f_cnt);

  // memory port: count read at address 0, particle reads from nxt_addr,
  // otherwise the address lingers at the last issued value
  always_comb begin
    rden    = 1'b0;
    rd_addr = last_addr;
    if (state == RD_CNT) begin
      rden    = 1'b1;
      rd_addr = '0;
    end else if (issue) begin
      rden    = 1'b1;
      rd_addr = nxt_addr;
    end
  end

  assign bus.mem_rden    = rden;
  assign bus.mem_address = rd_addr;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;

  assign bus.out_valid = f_vld[0];
  assign bus.out_data  = f_data[0];
  assign bus.out_index = f_idx[0];
  assign bus.out_last  = f_last[0];

  assign busy           = (state inside {RD_CNT, WAIT_CNT, STREAM, DRAIN});
  assign done           = (state == FINISH);
  assign particle_count = count_r;

  // state register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = RD_CNT;
      RD_CNT:   state_nx = WAIT_CNT;
      WAIT_CNT: if (cnt_ready) state_nx = (cnt_clamped == '0) ? FINISH : STREAM;
      STREAM:   if (issue && (nxt_addr == count_r)) state_nx = DRAIN;
      DRAIN:    if (pop && f_last[0]) state_nx = FINISH;
      FINISH:   state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // count latch, address generation and the count-wait timer
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      nxt_addr  <= '0;
      count_r   <= '0;
      wait_cnt  <= '0;
    end else begin
      if (rden) last_addr <= rd_addr;
      if (state == RD_CNT)        wait_cnt <= '0;
      else if (state == WAIT_CNT) wait_cnt <= wait_cnt + WCW'(1);
      if (cnt_ready) count_r <= cnt_clamped;
      if (state == WAIT_CNT) nxt_addr <= ADDR_WIDTH'(1);
      else if (issue)        nxt_addr <= nxt_addr + ADDR_WIDTH'(1);
    end
  end

  // in-flight tag shift register; reset discards anything still in flight
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      idx_pipe[1] <= nxt_addr;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  // output FIFO: shift on pop, then drop the returning word into the
  // first free slot (the push write wins over the shift for that slot)
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      f_vld  <= '0;
      f_last <= '0;
      f_data <= '0;
      f_idx  <= '0;
      f_cnt  <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
          f_vld[i]  <= f_vld[i+1];
          f_last[i] <= f_last[i+1];
          f_data[i] <= f_data[i+1];
          f_idx[i]  <= f_idx[i+1];
        end
        f_vld[FIFO_DEPTH-1]  <= 1'b0;
        f_last[FIFO_DEPTH-1] <= 1'b0;
        f_data[FIFO_DEPTH-1] <= '0;
        f_idx[FIFO_DEPTH-1]  <= '0;
      end
      if (push) begin
        f_vld[wr_pos]  <= 1'b1;
        f_last[wr_pos] <= (idx_pipe[RD_LATENCY] == count_r);
        f_data[wr_pos] <= bus.mem_q;
        f_idx[wr_pos]  <= idx_pipe[RD_LATENCY];
      end
      f_cnt <= f_cnt + FCW'(push) - FCW'(pop);
    end
  end

  // credit scheme guarantees a free slot for every return
  a_no_overflow: assert property (@(posedge clock) disable iff (!rst_n)
    !(push && !pop && (f_cnt == FCW'(FIFO_DEPTH))));

endmodule
